// File: rtl/link_fifo.sv
// link_fifo: point-to-point channel buffer between two routers. Flits arrive and
// leave on 4-phase req/ack handshakes through a circular store; packets are counted both ways.
module link_fifo #(
    parameter int ID         = 0,
    parameter int WIDTH      = 8,
    parameter int FLITS      = 8,
    parameter int DEPTH      = 16,
    parameter int DEPTH_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_req,
    input  logic [WIDTH-1:0]    in_flit,
    output logic                in_ack,
    output logic                out_req,
    output logic [WIDTH-1:0]    out_flit,
    input  logic                out_ack,
    output logic [DEPTH_BITS:0] level,
    output logic [15:0]         pkts_in,
    output logic [15:0]         pkts_out,
    output logic                busy
);
    localparam int CNT_BITS = $clog2(FLITS);
    localparam logic [DEPTH_BITS:0] FULL_LEVEL = (DEPTH_BITS + 1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] LEVEL_ONE  = (DEPTH_BITS + 1)'(1);
    localparam logic [DEPTH_BITS:0] LEVEL_ZERO = (DEPTH_BITS + 1)'(0);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_ONE    = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_LAST   = CNT_BITS'(FLITS - 1);

    if (DEPTH != (1 << DEPTH_BITS)) begin : g_param_check
        $error("link_fifo %0d: DEPTH must equal 2**DEPTH_BITS", ID);
    end

    typedef enum logic {
        IN_IDLE = 1'b0,
        IN_ACK  = 1'b1
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE = 2'd0,
        OUT_REQ  = 2'd1,
        OUT_WAIT = 2'd2
    } out_state_t;

    logic [WIDTH-1:0]      mem_r [DEPTH];
    in_state_t             in_state_r, in_state_nxt_s;
    out_state_t            out_state_r, out_state_nxt_s;
    logic [DEPTH_BITS-1:0] wr_ptr_r, rd_ptr_r;
    logic [DEPTH_BITS:0]   level_r, level_nxt_s;
    logic [CNT_BITS-1:0]   in_cnt_r, out_cnt_r;
    logic [15:0]           pkts_in_r, pkts_out_r;
    logic [WIDTH-1:0]      out_flit_r;
    logic                  in_ack_r, out_req_r, busy_r;
    logic                  write_s, launch_s, commit_s;

    // Upstream handshake: accept a flit whenever there is room, then wait for req to fall.
    always_comb begin
        in_state_nxt_s = in_state_r;
        write_s        = 1'b0;
        case (in_state_r)
            IN_IDLE: begin
                if (in_req && (level_r != FULL_LEVEL)) begin
                    write_s        = 1'b1;
                    in_state_nxt_s = IN_ACK;
                end else begin
                    in_state_nxt_s = IN_IDLE;
                end
            end
            IN_ACK: begin
                if (!in_req) begin
                    in_state_nxt_s = IN_IDLE;
                end else begin
                    in_state_nxt_s = IN_ACK;
                end
            end
            default: in_state_nxt_s = IN_IDLE;
        endcase
    end

    // Downstream handshake: the head entry is only released when the ack commits it.
    always_comb begin
        out_state_nxt_s = out_state_r;
        launch_s        = 1'b0;
        commit_s        = 1'b0;
        case (out_state_r)
            OUT_IDLE: begin
                if ((level_r != LEVEL_ZERO) && !out_ack) begin
                    launch_s        = 1'b1;
                    out_state_nxt_s = OUT_REQ;
                end else begin
                    out_state_nxt_s = OUT_IDLE;
                end
            end
            OUT_REQ: begin
                if (out_ack) begin
                    commit_s        = 1'b1;
                    out_state_nxt_s = OUT_WAIT;
                end else begin
                    out_state_nxt_s = OUT_REQ;
                end
            end
            OUT_WAIT: begin
                if (!out_ack) begin
                    out_state_nxt_s = OUT_IDLE;
                end else begin
                    out_state_nxt_s = OUT_WAIT;
                end
            end
            default: out_state_nxt_s = OUT_IDLE;
        endcase
    end

    // Occupancy: a write and a commit in the same cycle cancel out.
    always_comb begin
        level_nxt_s = level_r;
        if (write_s && !commit_s) begin
            level_nxt_s = level_r + LEVEL_ONE;
        end else if (commit_s && !write_s) begin
            level_nxt_s = level_r - LEVEL_ONE;
        end else begin
            level_nxt_s = level_r;
        end
    end

    // Flit storage; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (write_s) begin
            mem_r[wr_ptr_r] <= in_flit;
        end
    end

    // Control state, pointers, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_state_r  <= IN_IDLE;
            out_state_r <= OUT_IDLE;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            level_r     <= '0;
            in_cnt_r    <= '0;
            out_cnt_r   <= '0;
            pkts_in_r   <= 16'd0;
            pkts_out_r  <= 16'd0;
            out_flit_r  <= '0;
            in_ack_r    <= 1'b0;
            out_req_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_state_r  <= in_state_nxt_s;
            out_state_r <= out_state_nxt_s;
            level_r     <= level_nxt_s;
            in_ack_r    <= (in_state_nxt_s == IN_ACK);
            out_req_r   <= (out_state_nxt_s == OUT_REQ);
            busy_r      <= (level_nxt_s != LEVEL_ZERO) || (in_state_nxt_s != IN_IDLE) ||
                           (out_state_nxt_s != OUT_IDLE);
            if (write_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
                in_cnt_r <= in_cnt_r + CNT_ONE;
                if (in_cnt_r == CNT_LAST) begin
                    pkts_in_r <= pkts_in_r + 16'd1;
                end
            end
            if (launch_s) begin
                out_flit_r <= mem_r[rd_ptr_r];
            end
            if (commit_s) begin
                rd_ptr_r  <= rd_ptr_r + PTR_ONE;
                out_cnt_r <= out_cnt_r + CNT_ONE;
                if (out_cnt_r == CNT_LAST) begin
                    pkts_out_r <= pkts_out_r + 16'd1;
                end
            end
        end
    end

    assign in_ack   = in_ack_r;
    assign out_req  = out_req_r;
    assign out_flit = out_flit_r;
    assign level    = level_r;
    assign pkts_in  = pkts_in_r;
    assign pkts_out = pkts_out_r;
    assign busy     = busy_r;
endmodule

// File: tb/tb_link_fifo.sv
// Randomized bench for link_fifo: handshake agents on both sides, a queue-based
// reference model compared every cycle, and directed literal checks.
module tb_link_fifo;
    localparam int WIDTH      = 8;
    localparam int FLITS      = 8;
    localparam int DEPTH      = 16;
    localparam int DEPTH_BITS = 4;

    logic                clk     = 1'b0;
    logic                reset   = 1'b0;
    logic                in_req  = 1'b0;
    logic [WIDTH-1:0]    in_flit = '0;
    logic                out_ack = 1'b0;
    logic                in_ack, out_req, busy;
    logic [WIDTH-1:0]    out_flit;
    logic [DEPTH_BITS:0] level;
    logic [15:0]         pkts_in, pkts_out;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // reference model: flit queue plus the handshake phase of each side
    logic [WIDTH-1:0] mq[$];
    bit               m_in_ack, m_out_req, m_out_wait;
    logic [WIDTH-1:0] m_out_flit;
    longint unsigned  n_wr, n_rd;
    int               wc_seen = 0;

    logic [WIDTH-1:0] tx[$], sent[$], rcvd[$];
    int up_p  = 100;
    int dn_p  = 100;
    bit dn_en = 1'b1;

    link_fifo #(.ID(0), .WIDTH(WIDTH), .FLITS(FLITS), .DEPTH(DEPTH), .DEPTH_BITS(DEPTH_BITS)) dut (
        .clk(clk), .reset(reset), .in_req(in_req), .in_flit(in_flit), .in_ack(in_ack),
        .out_req(out_req), .out_flit(out_flit), .out_ack(out_ack), .level(level),
        .pkts_in(pkts_in), .pkts_out(pkts_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_in_ack   = 1'b0;
        m_out_req  = 1'b0;
        m_out_wait = 1'b0;
        m_out_flit = '0;
        n_wr       = 0;
        n_rd       = 0;
    endtask

    task automatic model_step();
        bit w, c, l;
        if (!reset) begin
            model_reset();
            return;
        end
        w = !m_in_ack && in_req && (mq.size() < DEPTH);
        c = m_out_req && out_ack;
        l = !m_out_req && !m_out_wait && (mq.size() > 0) && !out_ack;
        if (w && c) wc_seen++;
        if (m_in_ack && !in_req) m_in_ack = 1'b0;
        else if (w) m_in_ack = 1'b1;
        if (l) begin
            m_out_flit = mq[0];
            m_out_req  = 1'b1;
        end else if (c) begin
            m_out_req  = 1'b0;
            m_out_wait = 1'b1;
        end else if (m_out_wait && !out_ack) begin
            m_out_wait = 1'b0;
        end
        if (c) begin
            void'(mq.pop_front());
            n_rd++;
        end
        if (w) begin
            mq.push_back(in_flit);
            n_wr++;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ack",   32'(in_ack),   32'(m_in_ack));
            chk("out_req",  32'(out_req),  32'(m_out_req));
            chk("out_flit", 32'(out_flit), 32'(m_out_flit));
            chk("level",    32'(level),    32'(mq.size()));
            chk("pkts_in",  32'(pkts_in),  32'(16'(n_wr / FLITS)));
            chk("pkts_out", 32'(pkts_out), 32'(16'(n_rd / FLITS)));
            chk("busy",     32'(busy),
                32'((mq.size() != 0) || m_in_ack || m_out_req || m_out_wait));
            chk("level_max", 32'(level <= DEPTH), 32'd1);
        end
    end

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive();
        if (in_req && in_ack) begin
            in_req = 1'b0;
        end else if (!in_req && !in_ack && tx.size() > 0 && $urandom_range(99) < up_p) begin
            in_flit = tx.pop_front();
            sent.push_back(in_flit);
            in_req = 1'b1;
        end
        if (out_ack && !out_req) begin
            out_ack = 1'b0;
        end else if (!out_ack && out_req && dn_en && $urandom_range(99) < dn_p) begin
            rcvd.push_back(out_flit);
            out_ack = 1'b1;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            cycle();
            drive();
        end
    endtask

    task automatic run_until_idle(input int budget, input string name);
        int k = 0;
        while (!(tx.size() == 0 && !in_req && !in_ack && !out_req && !out_ack && mq.size() == 0)
               && k < budget) begin
            cycle();
            drive();
            k++;
        end
        chk({name, "_timeout"}, 32'(k < budget), 32'd1);
        run(2);
    endtask

    task automatic check_hist(input string name);
        int errs = 0;
        chk({name, "_count"}, 32'(rcvd.size()), 32'(sent.size()));
        foreach (rcvd[i]) begin
            if (i < sent.size() && rcvd[i] !== sent[i]) errs++;
        end
        chk({name, "_order"}, 32'(errs), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_in_ack",   32'(in_ack),   32'd0);
        chk("rst_out_req",  32'(out_req),  32'd0);
        chk("rst_out_flit", 32'(out_flit), 32'd0);
        chk("rst_level",    32'(level),    32'd0);
        chk("rst_pkts",     32'({pkts_in, pkts_out}), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        reset  = 1'b1;
        chk_en = 1'b1;

        // single flit latency
        in_flit = 8'hA5;
        in_req  = 1'b1;
        sent.push_back(8'hA5);
        cycle();
        chk("a5_in_ack",   32'(in_ack),  32'd1);
        chk("a5_req_early", 32'(out_req), 32'd0);
        in_req = 1'b0;
        cycle();
        chk("a5_out_req",  32'(out_req),  32'd1);
        chk("a5_out_flit", 32'(out_flit), 32'hA5);
        chk("a5_level",    32'(level),    32'd1);
        rcvd.push_back(out_flit);
        out_ack = 1'b1;
        run_until_idle(50, "a5");
        chk("a5_level_end", 32'(level),    32'd0);
        chk("a5_pkts_in",   32'(pkts_in),  32'd0);
        chk("a5_pkts_out",  32'(pkts_out), 32'd0);

        // eight sequential flits complete the first packet (9 flits total so far)
        for (int i = 0; i < 8; i++) tx.push_back(8'(i));
        run_until_idle(200, "seq8");
        chk("seq8_pkts_in",  32'(pkts_in),  32'd1);
        chk("seq8_pkts_out", 32'(pkts_out), 32'd1);
        chk("seq8_busy",     32'(busy),     32'd0);
        check_hist("seq8");

        // stalled downstream fills the FIFO; 17th flit is held off
        dn_en = 1'b0;
        for (int i = 0; i < 17; i++) tx.push_back(8'($urandom));
        run(60);
        chk("full_level",  32'(level),   32'd16);
        chk("full_in_ack", 32'(in_ack),  32'd0);
        chk("full_busy",   32'(busy),    32'd1);
        chk("full_head",   32'(out_flit), 32'(sent[9]));
        dn_en = 1'b1;
        run_until_idle(400, "full");
        check_hist("full");

        // random traffic crossing the pointer wrap
        for (int r = 0; r < 4; r++) begin
            up_p = int'($urandom_range(30, 100));
            dn_p = int'($urandom_range(30, 100));
            for (int i = 0; i < 50; i++) tx.push_back(8'($urandom));
            run_until_idle(3000, "rand");
        end
        check_hist("rand");
        chk("wc_seen", 32'(wc_seen > 0), 32'd1);

        // reset while a request is outstanding and five flits are queued
        up_p  = 100;
        dn_p  = 100;
        dn_en = 1'b0;
        for (int i = 0; i < 5; i++) tx.push_back(8'($urandom));
        run(30);
        chk("pre_rst_level",   32'(level),   32'd5);
        chk("pre_rst_out_req", 32'(out_req), 32'd1);
        #2;
        reset   = 1'b0;
        in_req  = 1'b0;
        out_ack = 1'b0;
        model_reset();
        tx.delete();
        sent.delete();
        rcvd.delete();
        #1;
        chk("mid_rst_out_req", 32'(out_req), 32'd0);
        chk("mid_rst_in_ack",  32'(in_ack),  32'd0);
        chk("mid_rst_level",   32'(level),   32'd0);
        chk("mid_rst_busy",    32'(busy),    32'd0);
        cycle();
        cycle();
        reset = 1'b1;
        dn_en = 1'b1;
        run(6);
        chk("post_rst_out_req", 32'(out_req), 32'd0);
        chk("post_rst_level",   32'(level),   32'd0);

        // traffic resumes cleanly after reset
        for (int i = 0; i < 10; i++) tx.push_back(8'($urandom));
        run_until_idle(300, "post");
        check_hist("post");
        chk("post_pkts_in", 32'(pkts_in), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
